fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 16-bit RISC core. Owns the program counter and drives
//  the address of the combinational instruction_mem, which returns the instruction in the same cycle.
//  Each fetched word is registered, with its PC, into a one-deep output stage; decode drains it
//  over a valid/ready handshake. Handles branch/jump redirects, HALT detection, and a fetch counter.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  PC_STEP    16'd1     PC increment per fetch (word-addressed memory)
//  HALT_OP    4'hF      opcode (instr[15:12]) that stops fetching
// PORTS
//  clk            in   1   core clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_pc        out  16  address to instruction_mem .pc; equals pc_q (combinational)
//  imem_instr     in   16  instruction_mem .instr_out; valid in the same cycle as imem_pc
//  instr          out  16  registered instruction presented to decode
//  instr_pc       out  16  PC of the instruction on instr
//  instr_valid    out  1   instr/instr_pc hold a valid instruction
//  instr_ready    in   1   decode accepts instr this cycle
//  redirect_valid in   1   branch/jump taken; flush and load redirect_pc
//  redirect_pc    in   16  target PC
//  halted         out  1   fetch is stopped in the HALT state
//  fetch_count    out  16  number of instructions captured; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, state=BOOT, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.
//  FSM states:
//   BOOT: lasts one cycle after reset is released, with no fetch. Next state is RUN.
//   RUN:  normal fetch.
//   HALT: no fetch. A redirect moves the FSM to RUN; otherwise it stays in HALT.
//  Fetch enable: fire = (state==RUN) & ~redirect_valid & (~instr_valid | instr_ready).
//  On fire:
//   instr<=imem_instr, instr_pc<=pc_q, instr_valid<=1, pc_q<=pc_q+PC_STEP.
//   The PC addition is mod 2^16, so 16'hFFFF+1 wraps to 16'h0000.
//   fetch_count increments by 1 and holds at 16'hFFFF.
//   If imem_instr[15:12]==HALT_OP, the word is still delivered, pc_q still advances,
//   and next state is HALT (halted=1).
//  On instr_ready & instr_valid without fire: instr_valid<=0 (instr/instr_pc hold their values).
//  Redirect (any state except BOOT) has highest priority:
//   pc_q<=redirect_pc, instr_valid<=0 (the word in the output stage is dropped even if
//   instr_ready=1), no capture that cycle, state<=RUN.
//   The first target instruction appears on instr one cycle later (two edges after the redirect).
//  Redirect during BOOT is ignored; BOOT always completes to RUN with pc_q=RESET_PC.
//  Throughput: 1 instr/cycle when instr_ready is held high. Latency from PC to instr_valid: 1 cycle.
//  Backpressure (instr_valid=1, instr_ready=0): instr, instr_pc, pc_q and fetch_count all hold.
//  In HALT, a pending instruction in the output stage stays valid until decode accepts it.
//  Asynchronous reset mid-operation immediately returns every output to its reset value.
// STRUCTURE
//  Shared package (core_pkg): the opcode field slice [15:12], the HALT opcode constant,
//  the RESET_PC default, and the fetch FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2).
//  Single module; no sub-module. instruction_mem is instantiated beside it at core level, not inside.
// TESTING (bench instantiates fetch_ctrl + instruction_mem, preloaded with a known image)
//  1 Reset, then release with instr_ready=1 -> instr_valid=0 during BOOT. From cycle 2 onward,
//    instr_pc runs 0,1,2,3... with instr = mem[instr_pc]; fetch_count increments each cycle.
//  2 Hold instr_ready=0 for 3 cycles while instr_pc=5 -> instr, instr_pc=5 and imem_pc=6 are stable.
//    Raise instr_ready -> the next word has instr_pc=6, with no skip and no duplicate.
//  3 Pulse redirect_valid with redirect_pc=16'd30 while instr_pc=8 -> the next cycle has
//    instr_valid=0. The cycle after that has instr_pc=30, then 31; word 9 is never delivered.
//  4 Place HALT_OP word at mem[57] and redirect to 57 -> the word at 57 is delivered,
//    halted=1, and instr_valid drops after acceptance. Then redirect to 158 -> halted=0 and
//    the next delivered instr_pc=158.
//  5 Redirect to 16'hFFFE -> instr_pc sequence is FFFE, FFFF, 0000, 0001 (wrap);
//    force fetch_count to saturate and check it holds at FFFF.
//  6 Assert rst_n=0 mid-stream while instr_valid=1 -> outputs clear asynchronously;
//    after release, fetch restarts at RESET_PC following the BOOT cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit RISC core front end.
//   - OP_HI/OP_LO : bit positions of the opcode field inside an instruction word
//   - HALT_OP_C   : opcode that stops instruction fetch
//   - RESET_PC_C  : default program counter after reset
//   - fetch_state_e : fetch sequencer state encoding
//   - opcode_of() : extracts the opcode field from an instruction word
package core_pkg;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;

  localparam logic [3:0]  HALT_OP_C  = 4'hF;
  localparam logic [15:0] RESET_PC_C = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the PC, addresses the combinational
// instruction memory and registers each fetched word (with its PC) into a
// one-deep output stage that decode drains over valid/ready.
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   imem_pc / imem_instr     memory address out, instruction word back (same cycle)
//   instr, instr_pc          registered instruction and its PC
//   instr_valid/instr_ready  output-stage handshake with decode
//   redirect_valid/_pc       taken branch/jump: flush and restart at target
//   halted                   fetch stopped after a HALT opcode
//   fetch_count              saturating count of captured instructions
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_C,
  parameter logic [15:0] PC_STEP  = 16'd1,
  parameter logic [3:0]  HALT_OP  = HALT_OP_C
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instr,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halted_q, halted_d;
  logic [15:0]  fetch_count_q, fetch_count_d;
  logic         fire_s;

  assign imem_pc     = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

  // Capture a new word when running, not flushing, and the output stage is free or draining.
  assign fire_s = (state_q == ST_RUN) & ~redirect_valid & (~instr_valid_q | instr_ready);

  // Next-state logic for the fetch sequencer and its output stage.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_BOOT: begin
        // Redirects are ignored here; fetch always begins at the reset PC.
        pc_d    = RESET_PC;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // Flush: the pending word is dropped even if decode is accepting it.
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = ST_RUN;
        end else if (fire_s) begin
          instr_d       = imem_instr;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + PC_STEP;
          fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;
          // The HALT word itself is still delivered to decode.
          state_d       = (opcode_of(imem_instr) == HALT_OP) ? ST_HALT : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = ST_RUN;
        end else if (instr_valid_q & instr_ready) begin
          instr_valid_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d       = ST_BOOT;
        pc_d          = RESET_PC;
        instr_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  // Sequencer state, PC, output stage and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. A behavioural instruction memory image
// is attached combinationally; expected delivered PCs are queued as stimulus
// is driven and popped when decode accepts a word.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int failures = 0;
  logic chk_cnt = 1'b0;
  logic [15:0] exp_q[$];

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  // Memory image: a HALT word at 57, elsewhere opcodes 4..7 derived from the address.
  function automatic logic [15:0] imem_word(input logic [15:0] a);
    logic [13:0] low;
    if (a == 16'd57) return 16'hF039;
    low = a[13:0] ^ 14'h1555;
    return {2'b01, low};
  endfunction

  assign imem_instr = imem_word(imem_pc);

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, then score any accepted word.
  task automatic cycle(input logic rdy, input logic rv, input logic [15:0] rpc);
    logic [15:0] e;
    @(negedge clk);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (instr_valid && rdy && !rv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_pc", {16'h0, instr_pc}, {16'h0, e});
        chk("deliver_instr", {16'h0, instr}, {16'h0, imem_word(e)});
        if (chk_cnt) chk("deliver_count", {16'h0, fetch_count}, {16'h0, e + 16'd1});
      end
    end
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() > 0; i++) cycle(1'b1, 1'b0, 16'h0000);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset
    instr_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_instr", {16'h0, instr}, 32'd0);
    chk("rst_instr_pc", {16'h0, instr_pc}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_count", {16'h0, fetch_count}, 32'd0);
    chk("rst_imem_pc", {16'h0, imem_pc}, 32'd0);
    rst_n = 1'b1;
    #1 chk("boot_valid", {31'h0, instr_valid}, 32'd0);

    // Test 1: stream from reset PC
    chk_cnt = 1'b1;
    cycle(1'b1, 1'b0, 16'h0000);
    chk("boot2_valid", {31'h0, instr_valid}, 32'd0);
    for (int i = 0; i < 5; i++) exp_q.push_back(16'(i));
    drain(10);

    // Test 2: backpressure at instr_pc=5
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      chk("bp_valid", {31'h0, instr_valid}, 32'd1);
      chk("bp_instr_pc", {16'h0, instr_pc}, 32'd5);
      chk("bp_instr", {16'h0, instr}, {16'h0, imem_word(16'd5)});
      chk("bp_imem_pc", {16'h0, imem_pc}, 32'd6);
      chk("bp_count", {16'h0, fetch_count}, 32'd6);
    end
    for (int i = 5; i < 8; i++) exp_q.push_back(16'(i));
    drain(10);
    chk_cnt = 1'b0;

    // Test 3: redirect while instr_pc=8
    cycle(1'b1, 1'b1, 16'd30);
    chk("redir_src_pc", {16'h0, instr_pc}, 32'd8);
    cycle(1'b1, 1'b0, 16'h0000);
    chk("redir_bubble", {31'h0, instr_valid}, 32'd0);
    exp_q.push_back(16'd30);
    exp_q.push_back(16'd31);
    drain(10);

    // Test 4: HALT word at 57, then restart at 158
    cycle(1'b1, 1'b1, 16'd57);
    exp_q.push_back(16'd57);
    cycle(1'b1, 1'b0, 16'h0000);
    chk("halt_bubble", {31'h0, instr_valid}, 32'd0);
    cycle(1'b0, 1'b0, 16'h0000);
    chk("halt_word_valid", {31'h0, instr_valid}, 32'd1);
    chk("halt_word_pc", {16'h0, instr_pc}, 32'd57);
    chk("halt_word", {16'h0, instr}, 32'h0000F039);
    chk("halted_set", {31'h0, halted}, 32'd1);
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0000);
    chk("halt_drained", {31'h0, instr_valid}, 32'd0);
    chk("halt_still", {31'h0, halted}, 32'd1);
    chk("halt_pc", {16'h0, imem_pc}, 32'd58);
    cycle(1'b1, 1'b1, 16'd158);
    cycle(1'b1, 1'b0, 16'h0000);
    chk("unhalt", {31'h0, halted}, 32'd0);
    exp_q.push_back(16'd158);
    exp_q.push_back(16'd159);
    drain(10);

    // Test 5: PC wrap and counter saturation
    cycle(1'b1, 1'b1, 16'hFFFE);
    cycle(1'b1, 1'b0, 16'h0000);
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    drain(10);
    cycle(1'b0, 1'b0, 16'h0000);
    force dut.fetch_count_q = 16'hFFFD;
    #1 release dut.fetch_count_q;
    chk("sat_preload", {16'h0, fetch_count}, 32'h0000FFFD);
    for (int i = 2; i < 6; i++) exp_q.push_back(16'(i));
    drain(10);
    chk("sat_hold", {16'h0, fetch_count}, 32'h0000FFFF);
    cycle(1'b0, 1'b0, 16'h0000);
    chk("sat_bp", {16'h0, fetch_count}, 32'h0000FFFF);

    // Test 6: asynchronous reset mid-stream
    chk("pre_rst_valid", {31'h0, instr_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, instr_valid}, 32'd0);
    chk("arst_instr", {16'h0, instr}, 32'd0);
    chk("arst_instr_pc", {16'h0, instr_pc}, 32'd0);
    chk("arst_count", {16'h0, fetch_count}, 32'd0);
    chk("arst_imem_pc", {16'h0, imem_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    cycle(1'b1, 1'b0, 16'h0000);
    chk("reboot_valid", {31'h0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
